// File: rtl/daynight_ctrl.sv
// daynight_ctrl: day/night sequencer for the colour palette stage.
// The block counts score ticks through DAY and NIGHT. It fades between them
// one level per FADE_STEP frames, with L running from 0 up to 16 or back
// down. It produces a registered per-pixel night select, one cycle after
// DrawX/DrawY.
// Optional feature macro: DAYNIGHT_DITHER_EN
//   defined   -> 4x4 Bayer ordered dither: isnight = (t < L)
//   undefined -> hard switch at mid-fade: isnight = (L >= 8)
module daynight_ctrl #(
  parameter int DAY_TICKS   = 70,
  parameter int NIGHT_TICKS = 30,
  parameter int FADE_STEP   = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_start,
  input  logic       score_tick,
  input  logic       game_reset,
  input  logic       pause,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       isnight,
  output logic [4:0] fade_level,
  output logic [1:0] state
);

  localparam int MAX_TICKS = (DAY_TICKS > NIGHT_TICKS) ? DAY_TICKS : NIGHT_TICKS;
  localparam int TW = $clog2(MAX_TICKS + 1);
  localparam int FW = $clog2(FADE_STEP + 1);
  localparam logic [TW-1:0] DAY_LIM   = TW'(DAY_TICKS);
  localparam logic [TW-1:0] NIGHT_LIM = TW'(NIGHT_TICKS);
  localparam logic [FW-1:0] STEP_LIM  = FW'(FADE_STEP);

  typedef enum logic [1:0] {
    ST_DAY      = 2'b00,
    ST_TO_NIGHT = 2'b01,
    ST_NIGHT    = 2'b10,
    ST_TO_DAY   = 2'b11
  } state_t;

  state_t        r_state;
  logic [4:0]    r_level;
  logic [TW-1:0] r_tick_cnt;
  logic [FW-1:0] r_frame_cnt;
  logic          r_isnight;

  logic [TW-1:0] w_tick_inc;
  logic [FW-1:0] w_frame_inc;
  logic          w_frame_done;
  logic          w_night_sel;

  assign w_tick_inc   = r_tick_cnt + 1'b1;
  assign w_frame_inc  = r_frame_cnt + 1'b1;
  assign w_frame_done = (w_frame_inc == STEP_LIM);

`ifdef DAYNIGHT_DITHER_EN
  logic [3:0] w_thresh;
  logic       w_unused_hi_bits;

  // Only the low two bits of each coordinate select the dither phase.
  assign w_unused_hi_bits = ^{DrawX[9:2], DrawY[9:2]};

  // 4x4 Bayer threshold lookup indexed by {row, column}.
  always_comb begin
    w_thresh = 4'd0;
    case ({DrawY[1:0], DrawX[1:0]})
      4'b00_00: w_thresh = 4'd0;
      4'b00_01: w_thresh = 4'd8;
      4'b00_10: w_thresh = 4'd2;
      4'b00_11: w_thresh = 4'd10;
      4'b01_00: w_thresh = 4'd12;
      4'b01_01: w_thresh = 4'd4;
      4'b01_10: w_thresh = 4'd14;
      4'b01_11: w_thresh = 4'd6;
      4'b10_00: w_thresh = 4'd3;
      4'b10_01: w_thresh = 4'd11;
      4'b10_10: w_thresh = 4'd1;
      4'b10_11: w_thresh = 4'd9;
      4'b11_00: w_thresh = 4'd15;
      4'b11_01: w_thresh = 4'd7;
      4'b11_10: w_thresh = 4'd13;
      4'b11_11: w_thresh = 4'd5;
      default:  w_thresh = 4'd0;
    endcase
  end

  assign w_night_sel = ({1'b0, w_thresh} < r_level);
`else
  logic w_unused_coords;

  // Coordinates are not needed when the switch is a flat mid-fade threshold.
  assign w_unused_coords = ^{DrawX, DrawY};
  assign w_night_sel     = (r_level >= 5'd8);
`endif

  // Sequencer: tick counting in DAY/NIGHT, frame-stepped level in the fades.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= ST_DAY;
      r_level     <= 5'd0;
      r_tick_cnt  <= '0;
      r_frame_cnt <= '0;
    end else if (game_reset) begin
      r_state     <= ST_DAY;
      r_level     <= 5'd0;
      r_tick_cnt  <= '0;
      r_frame_cnt <= '0;
    end else if (!pause) begin
      case (r_state)
        ST_DAY: begin
          if (score_tick) begin
            if (w_tick_inc == DAY_LIM) begin
              r_tick_cnt <= '0;
              r_state    <= ST_TO_NIGHT;
            end else begin
              r_tick_cnt <= w_tick_inc;
            end
          end
        end
        ST_TO_NIGHT: begin
          if (frame_start) begin
            if (w_frame_done) begin
              r_frame_cnt <= '0;
              r_level     <= r_level + 5'd1;
              if (r_level == 5'd15) r_state <= ST_NIGHT;
            end else begin
              r_frame_cnt <= w_frame_inc;
            end
          end
        end
        ST_NIGHT: begin
          if (score_tick) begin
            if (w_tick_inc == NIGHT_LIM) begin
              r_tick_cnt <= '0;
              r_state    <= ST_TO_DAY;
            end else begin
              r_tick_cnt <= w_tick_inc;
            end
          end
        end
        ST_TO_DAY: begin
          if (frame_start) begin
            if (w_frame_done) begin
              r_frame_cnt <= '0;
              r_level     <= r_level - 5'd1;
              if (r_level == 5'd1) r_state <= ST_DAY;
            end else begin
              r_frame_cnt <= w_frame_inc;
            end
          end
        end
        default: r_state <= ST_DAY;
      endcase
    end
  end

  // Pixel select register; keeps running under pause so the picture stays live.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_isnight <= 1'b0;
    end else if (game_reset) begin
      r_isnight <= 1'b0;
    end else begin
      r_isnight <= w_night_sel;
    end
  end

  assign isnight    = r_isnight;
  assign fade_level = r_level;
  assign state      = r_state;

endmodule

// File: tb/tb_daynight_ctrl.sv
// Bench for daynight_ctrl with DAY_TICKS=3, NIGHT_TICKS=2, FADE_STEP=2.
// The reference model tracks phase, the ticks seen in the current phase and
// the frames seen in the current fade. Level is derived from those counts.
module tb_daynight_ctrl;

  localparam int DAY_T = 3;
  localparam int NIGHT_T = 2;
  localparam int FSTEP = 2;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_start, score_tick, game_reset, pause;
  logic [9:0] DrawX, DrawY;
  logic       isnight;
  logic [4:0] fade_level;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail = 0;

  // model state
  int   m_phase;   // 0 day, 1 to_night, 2 night, 3 to_day
  int   m_ticks;   // ticks counted in the current steady phase
  int   m_frames;  // frames counted since the current fade began
  logic m_isnight;
  int   bayer[4][4];

  daynight_ctrl #(.DAY_TICKS(DAY_T), .NIGHT_TICKS(NIGHT_T), .FADE_STEP(FSTEP)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .score_tick(score_tick),
    .game_reset(game_reset), .pause(pause), .DrawX(DrawX), .DrawY(DrawY),
    .isnight(isnight), .fade_level(fade_level), .state(state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  function automatic int m_level();
    case (m_phase)
      0:       return 0;
      1:       return m_frames / FSTEP;
      2:       return 16;
      default: return 16 - m_frames / FSTEP;
    endcase
  endfunction

  function automatic logic m_pixel(input int x, input int y, input int lvl);
`ifdef DAYNIGHT_DITHER_EN
    return (bayer[y % 4][x % 4] < lvl);
`else
    return (lvl >= 8);
`endif
  endfunction

  function automatic logic [7:0] exp_vec();
    int lv;
    lv = m_level();
    return {2'(m_phase), 5'(lv), m_isnight};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ticks = 0; m_frames = 0; m_isnight = 1'b0;
  endtask

  task automatic model_step(input logic fs, input logic st, input logic gr, input logic pz,
                            input int x, input int y);
    if (gr) begin
      model_reset();
      return;
    end
    m_isnight = m_pixel(x, y, m_level());
    if (pz) return;
    if (m_phase == 0 || m_phase == 2) begin
      if (st) begin
        m_ticks++;
        if (m_ticks == ((m_phase == 0) ? DAY_T : NIGHT_T)) begin
          m_ticks = 0;
          m_phase = m_phase + 1;
        end
      end
    end else if (fs) begin
      m_frames++;
      if (m_frames == 16 * FSTEP) begin
        m_frames = 0;
        m_phase = (m_phase + 1) % 4;
      end
    end
  endtask

  // driver: one clock cycle of stimulus, model advanced at the edge
  task automatic drive(input logic fs, input logic st, input logic gr, input logic pz,
                       input int x, input int y);
    @(negedge Clk);
    frame_start = fs; score_tick = st; game_reset = gr; pause = pz;
    DrawX = 10'(x); DrawY = 10'(y);
    @(posedge Clk);
    model_step(fs, st, gr, pz, x, y);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, $urandom_range(0, 639), $urandom_range(0, 479));
  endtask

  task automatic goto_to_night();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < DAY_T; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      idle($urandom_range(0, 2));
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, $urandom_range(0, 639), $urandom_range(0, 479));
      idle($urandom_range(0, 2));
    end
  endtask

  task automatic test_reset();
    goto_to_night();
    frames(6);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    // asynchronous reset mid-cycle, sampled before any clock edge
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    n_checks++;
    if ({state, fade_level, isnight} !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: got state=%b L=%0d isnight=%b, want 00/0/0", state, fade_level, isnight);
    end
    model_reset();
    frame_start = 1'b0; score_tick = 1'b0; game_reset = 1'b0; pause = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < DAY_T; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      n_checks++;
      if (state !== ((i == DAY_T - 1) ? 2'b01 : 2'b00) || {state, fade_level, isnight} !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_ticks[%0d]: got %b/%0d/%b, want %h", i, state, fade_level, isnight, exp_vec());
      end
    end
  endtask

  task automatic test_fade_dither();
    frames(2);
    n_checks++;
    if (fade_level !== 5'd1 || {state, fade_level, isnight} !== exp_vec()) begin
      n_fail++;
      $display("FAIL first_step: got L=%0d state=%b, want L=1 state=01", fade_level, state);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    n_checks++;
    if ({state, fade_level, isnight} !== exp_vec()) begin
      n_fail++;
      $display("FAIL pixel_00: got isnight=%b, want %b", isnight, m_isnight);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    n_checks++;
    if (isnight !== 1'b0 || {state, fade_level, isnight} !== exp_vec()) begin
      n_fail++;
      $display("FAIL pixel_10: got isnight=%b, want 0", isnight);
    end
  endtask

  task automatic test_full_cycle();
    int guard;
    guard = 0;
    while (m_phase == 1 && guard < 200) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, $urandom_range(0, 639), $urandom_range(0, 479));
      guard++;
      n_checks++;
      if ({state, fade_level, isnight} !== exp_vec()) begin
        n_fail++;
        $display("FAIL fade_up: got %b/%0d/%b, want %h", state, fade_level, isnight, exp_vec());
      end
    end
    n_checks++;
    if (state !== 2'b10 || fade_level !== 5'd16) begin
      n_fail++;
      $display("FAIL reach_night: got state=%b L=%0d, want 10/16", state, fade_level);
    end
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, x, y);
        n_checks++;
        if (isnight !== 1'b1) begin
          n_fail++;
          $display("FAIL night_px(%0d,%0d): got %b, want 1", x, y, isnight);
        end
      end
    for (int i = 0; i < NIGHT_T; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 0, 0);
      n_checks++;
      if ({state, fade_level, isnight} !== exp_vec()) begin
        n_fail++;
        $display("FAIL night_ticks[%0d]: got %b/%0d/%b, want %h", i, state, fade_level, isnight, exp_vec());
      end
    end
    n_checks++;
    if (state !== 2'b11) begin
      n_fail++;
      $display("FAIL reach_to_day: got state=%b, want 11", state);
    end
    guard = 0;
    while (m_phase == 3 && guard < 200) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, $urandom_range(0, 639), $urandom_range(0, 479));
      guard++;
      n_checks++;
      if ({state, fade_level, isnight} !== exp_vec()) begin
        n_fail++;
        $display("FAIL fade_down: got %b/%0d/%b, want %h", state, fade_level, isnight, exp_vec());
      end
    end
    n_checks++;
    if (state !== 2'b00 || fade_level !== 5'd0 || guard != 2 * 16 * FSTEP / 2 * 2 / 2 * 1) begin
      n_fail++;
      $display("FAIL reach_day: got state=%b L=%0d frames=%0d, want 00/0/%0d", state, fade_level, guard, 16 * FSTEP);
    end
  endtask

  task automatic test_game_reset();
    goto_to_night();
    frames(5 * FSTEP);
    n_checks++;
    if (fade_level !== 5'd5) begin
      n_fail++;
      $display("FAIL pre_greset: got L=%0d, want 5", fade_level);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    n_checks++;
    if ({state, fade_level, isnight} !== 8'h00 || exp_vec() !== 8'h00) begin
      n_fail++;
      $display("FAIL game_reset: got %b/%0d/%b, want 00/0/0", state, fade_level, isnight);
    end
  endtask

  task automatic test_pause();
    goto_to_night();
    frames(3 * FSTEP + 1);
    for (int i = 0; i < 15; i++) begin
      drive(1'(i < 10), 1'(i >= 10), 1'b0, 1'b1, $urandom_range(0, 639), $urandom_range(0, 479));
      n_checks++;
      if (fade_level !== 5'd3 || {state, fade_level, isnight} !== exp_vec()) begin
        n_fail++;
        $display("FAIL pause_fade[%0d]: got %b/%0d/%b, want %h", i, state, fade_level, isnight, exp_vec());
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    n_checks++;
    if (fade_level !== 5'd4 || {state, fade_level, isnight} !== exp_vec()) begin
      n_fail++;
      $display("FAIL pause_resume: got L=%0d, want 4", fade_level);
    end
    // paused ticks in DAY are dropped as well
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < DAY_T - 1; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
    n_checks++;
    if (state !== 2'b00 || {state, fade_level, isnight} !== exp_vec()) begin
      n_fail++;
      $display("FAIL pause_ticks: got state=%b, want 00", state);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    n_checks++;
    if (state !== 2'b01 || {state, fade_level, isnight} !== exp_vec()) begin
      n_fail++;
      $display("FAIL pause_tick_resume: got state=%b, want 01", state);
    end
  endtask

  task automatic test_threshold();
    goto_to_night();
    for (int lv = 0; lv <= 16; lv++) begin
      for (int y = 0; y < 4; y++)
        for (int x = 0; x < 4; x++) begin
          drive(1'b0, 1'b0, 1'b0, 1'b0, x + 4 * $urandom_range(0, 150), y + 4 * $urandom_range(0, 110));
          n_checks++;
          if ({state, fade_level, isnight} !== exp_vec()) begin
            n_fail++;
            $display("FAIL threshold L=%0d (%0d,%0d): got %b, want %b", lv, x, y, isnight, m_isnight);
          end
        end
      if (lv < 16) frames(FSTEP);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 399) == 0), 1'($urandom_range(0, 7) == 0),
            $urandom_range(0, 639), $urandom_range(0, 479));
      n_checks++;
      if ({state, fade_level, isnight} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %b/%0d/%b, want %h", i, state, fade_level, isnight, exp_vec());
      end
    end
  endtask

  initial begin
    bayer = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
    model_reset();
    Reset_n = 1'b0;
    frame_start = 1'b0; score_tick = 1'b0; game_reset = 1'b0; pause = 1'b0;
    DrawX = '0; DrawY = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    n_checks++;
    if ({state, fade_level, isnight} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: got %b/%0d/%b, want 00/0/0", state, fade_level, isnight);
    end
    test_reset();
    test_fade_dither();
    test_full_cycle();
    test_game_reset();
    test_pause();
    test_threshold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/daynight_ctrl.md
# daynight_ctrl

Generates the per-pixel `isnight` select consumed by the colour palette stage. It tracks game progress via score ticks, sequences DAY → TO_NIGHT → NIGHT → TO_DAY, and renders each transition as a frame-stepped 4x4 ordered-dither fade. It sits between the game-logic/VGA-timing blocks and the palette; the palette's `color` input must be delayed one cycle to align with this block's registered output.

## Interface
Parameters:
- `DAY_TICKS`, 70: score ticks spent in DAY before a fade to night starts (≥1).
- `NIGHT_TICKS`, 30: score ticks spent in NIGHT before a fade to day starts (≥1).
- `FADE_STEP`, 4: frames per fade-level step (≥1).

Ports:
- `Clk`  input  1  pixel-domain clock.
- `Reset_n`  input  1  asynchronous, active-low reset.
- `frame_start`  input  1  one-cycle pulse per frame (start of VSync).
- `score_tick`  input  1  one-cycle pulse per score increment.
- `game_reset`  input  1  synchronous clear to DAY (new game).
- `pause`  input  1  freezes tick counting and fade progress while high.
- `DrawX`  input  10  current pixel column.
- `DrawY`  input  10  current pixel row.
- `isnight`  output  1  registered palette night select for the pixel presented on the previous cycle.
- `fade_level`  output  5  current level L, 0..16.
- `state`  output  2  00 DAY, 01 TO_NIGHT, 10 NIGHT, 11 TO_DAY.

## Operation
- Reset (`Reset_n` low, async) clears state to DAY, L to 0, tick counter to 0, frame-step counter to 0, and `isnight` to 0.
- DAY: L=0. Each unpaused `score_tick` increments the tick counter. When the increment reaches `DAY_TICKS`, the counter clears and the state moves to TO_NIGHT.
- TO_NIGHT: each unpaused `frame_start` increments the frame-step counter. When that increment reaches `FADE_STEP`, the counter clears and L increments. When L reaches 16, the state moves to NIGHT.
- NIGHT: L=16. Ticks are counted against `NIGHT_TICKS`, then the state moves to TO_DAY.
- TO_DAY: same as TO_NIGHT, except L decrements. When L reaches 0, the state moves to DAY.
- Score ticks arriving during TO_NIGHT/TO_DAY are ignored; the tick counter stays 0.
- Dither threshold t = B[DrawY[1:0]][DrawX[1:0]], Bayer rows:
  - y0: 0 8 2 10
  - y1: 12 4 14 6
  - y2: 3 11 1 9
  - y3: 15 7 13 5
- Registered `isnight` = (t < L). L=0 gives all day; L=16 gives all night.
- Tick counter width is $clog2(max(DAY_TICKS,NIGHT_TICKS)+1). The frame-step counter width is $clog2(FADE_STEP+1). Neither counter wraps except by the explicit clear.

## Timing
- `isnight` latency: 1 cycle from `DrawX`/`DrawY`.
- `state` and `fade_level` are registered and update on the cycle after the triggering pulse.
- Priority: `game_reset` > `pause` > normal operation.
  - `game_reset` clears everything to reset values on the next edge, including mid-fade.
  - `pause` blocks both pulse types; held pulses are lost, not queued.
- `frame_start` and `score_tick` in the same cycle: both are evaluated against the current state.
  - In DAY/NIGHT, the tick counts and the frame is irrelevant.
  - In a fade, the frame steps and the tick is ignored.
- A level change takes effect on the next pixel cycle. Because `frame_start` is at VSync, no visible frame mixes levels.
- The final-step transition to NIGHT or DAY occurs in the same cycle that L reaches 16 or 0.

## Configuration
- `DAYNIGHT_DITHER_EN` defined: Bayer dither as above.
- Undefined: no threshold logic, `isnight` = (L ≥ 8), registered, still 1-cycle latency. This gives a hard switch at mid-fade. State and level sequencing are unchanged.

## Test plan
Test parameters: DAY_TICKS=3, NIGHT_TICKS=2, FADE_STEP=2, dither enabled.

- Reset low mid-operation → `isnight`=0, `state`=00, `fade_level`=0 immediately. After release, 2 ticks → still DAY; 3rd tick → `state`=01.
- In TO_NIGHT, 2 `frame_start` → L=1. Then:
  - Pixel (0,0) → `isnight`=1 one cycle later.
  - Pixel (1,0) (t=8) → 0.
- After 32 frames from the start of TO_NIGHT → L=16, `state`=10, all 16 pixel phases give 1. Then 2 ticks → `state`=11. After 32 more frames → `state`=00, L=0.
- In TO_NIGHT at L=5, assert `game_reset` together with `frame_start` → next cycle `state`=00, L=0, `isnight`=0.
- Hold `pause` over 10 `frame_start`s and 5 ticks → L and counters unchanged. Releasing resumes from the same values.
- Build without `DAYNIGHT_DITHER_EN`, in TO_NIGHT:
  - L=7 → `isnight`=0 at all pixels.
  - L=8 → `isnight`=1 at all pixels.
